// File: rtl/chen_frame_sync_pkg.sv
// Shared definitions for the sync-word hunter/framer: FSM state encoding
// and the default sync symbol.
package chen_frame_sync_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_e;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'h47;

endpackage

// File: rtl/chen_frame_sync.sv
// Frame synchroniser: hunts a periodic sync symbol, locks after LOCK_COUNT
// correctly spaced hits, then strips the sync and emits aligned payload bursts.
module chen_frame_sync
  import chen_frame_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    FRAME_LENGTH = 255,
  parameter int                    CNT_WIDTH    = 9,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = DATA_WIDTH'(SYNC_WORD_DEFAULT),
  parameter int                    LOCK_COUNT   = 3,
  parameter int                    UNLOCK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  data_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_start_o,
  output logic                  locked_o,
  output logic                  sync_err_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] POS_LAST    = CNT_WIDTH'(FRAME_LENGTH);
  localparam logic [GW-1:0]        GOOD_TARGET = GW'(LOCK_COUNT);
  localparam logic [MW-1:0]        MISS_TARGET = MW'(UNLOCK_COUNT);

  if (FRAME_LENGTH > (2 ** CNT_WIDTH) - 1) begin : g_bad_cnt_width
    $error("chen_frame_sync: CNT_WIDTH too small to hold FRAME_LENGTH");
  end
  if (LOCK_COUNT < 2) begin : g_bad_lock_count
    $error("chen_frame_sync: LOCK_COUNT must be at least 2");
  end
  if (UNLOCK_COUNT < 1) begin : g_bad_unlock_count
    $error("chen_frame_sync: UNLOCK_COUNT must be at least 1");
  end

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  pos_q, pos_d;
  logic [GW-1:0]         good_cnt_q, good_cnt_d;
  logic [MW-1:0]         miss_cnt_q, miss_cnt_d;

  logic                  data_en_q, data_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  frame_start_q, frame_start_d;
  logic                  locked_q, locked_d;
  logic                  sync_err_q, sync_err_d;

  logic                  is_sync;
  logic                  at_sync_pos;
  logic [GW-1:0]         good_cnt_inc;
  logic [MW-1:0]         miss_cnt_inc;

  assign is_sync      = (data_i == SYNC_WORD);
  assign at_sync_pos  = (pos_q == POS_LAST);
  assign good_cnt_inc = good_cnt_q + GW'(1);
  assign miss_cnt_inc = miss_cnt_q + MW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      pos_q         <= '0;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      data_en_q     <= 1'b0;
      data_q        <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      data_en_q     <= data_en_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Next state and counters; idle cycles leave everything frozen.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (data_en_i) begin
      case (state_q)
        ST_HUNT: begin
          if (is_sync) begin
            state_d    = ST_VERIFY;
            pos_d      = '0;
            good_cnt_d = GW'(1);
          end
        end
        ST_VERIFY: begin
          if (!at_sync_pos) begin
            pos_d = pos_q + CNT_WIDTH'(1);
          end else if (is_sync) begin
            pos_d      = '0;
            good_cnt_d = good_cnt_inc;
            if (good_cnt_inc == GOOD_TARGET) begin
              state_d    = ST_LOCK;
              miss_cnt_d = '0;
            end
          end else begin
            // The failing symbol is consumed here, not offered back to HUNT.
            state_d    = ST_HUNT;
            pos_d      = '0;
            good_cnt_d = '0;
          end
        end
        ST_LOCK: begin
          if (!at_sync_pos) begin
            pos_d = pos_q + CNT_WIDTH'(1);
          end else begin
            pos_d = '0;
            if (is_sync) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_inc;
              if (miss_cnt_inc == MISS_TARGET) begin
                state_d    = ST_HUNT;
                good_cnt_d = '0;
                miss_cnt_d = '0;
              end
            end
          end
        end
        default: begin
          state_d    = ST_HUNT;
          pos_d      = '0;
          good_cnt_d = '0;
          miss_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_en_d     = 1'b0;
    data_d        = '0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    locked_d      = (state_d == ST_LOCK);
    if (data_en_i && (state_q == ST_LOCK)) begin
      if (!at_sync_pos) begin
        data_en_d     = 1'b1;
        data_d        = data_i;
        frame_start_d = (pos_q == '0);
      end else begin
        sync_err_d = !is_sync;
      end
    end
  end

  assign data_en_o     = data_en_q;
  assign data_o        = data_q;
  assign frame_start_o = frame_start_q;
  assign locked_o      = locked_q;
  assign sync_err_o    = sync_err_q;

endmodule

// File: tb/tb_chen_frame_sync.sv
// Randomised bench for chen_frame_sync: an index-based reference model over
// the valid-symbol stream predicts every output cycle.
module tb_chen_frame_sync;

  localparam int DW     = 8;
  localparam int FL     = 255;
  localparam int PERIOD = FL + 1;
  localparam int SYNC   = 8'h47;
  localparam int LOCKN  = 3;
  localparam int UNLOCKN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_en_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          data_en_o;
  logic [DW-1:0] data_o;
  logic          frame_start_o;
  logic          locked_o;
  logic          sync_err_o;

  int chk_cnt = 0;
  int err_cnt = 0;

  int syms[$];
  int seg[$];
  bit m_en[];
  bit m_fs[];
  bit m_err[];
  bit m_lk[];

  always #5 clk = ~clk;

  chen_frame_sync #(
    .DATA_WIDTH  (DW),
    .FRAME_LENGTH(FL),
    .CNT_WIDTH   (9),
    .SYNC_WORD   (8'h47),
    .LOCK_COUNT  (LOCKN),
    .UNLOCK_COUNT(UNLOCKN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_en_i    (data_en_i),
    .data_i       (data_i),
    .data_en_o    (data_en_o),
    .data_o       (data_o),
    .frame_start_o(frame_start_o),
    .locked_o     (locked_o),
    .sync_err_o   (sync_err_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      if (err_cnt <= 50)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rand_non_sync();
    int v;
    do v = int'($urandom_range(0, 255)); while (v == SYNC);
    return v;
  endfunction

  // mode 0: payload counts 0..FL-1; mode 1: any byte; mode 2: any byte except sync
  task automatic add_frame(input int sync_val, input int mode);
    syms.push_back(sync_val);
    for (int i = 0; i < FL; i++) begin
      case (mode)
        0:       syms.push_back(i);
        1:       syms.push_back(int'($urandom_range(0, 255)));
        default: syms.push_back(rand_non_sync());
      endcase
    end
  endtask

  // Works on symbol indices: find a sync, test the candidates one period apart,
  // then mark payload windows while counting consecutive bad sync slots.
  task automatic build_model();
    int n, h, j, c, misses;
    bit verified, done;
    n = seg.size();
    m_en = new[n]; m_fs = new[n]; m_err = new[n]; m_lk = new[n];
    h = 0;
    while (h < n) begin
      j = h;
      while (j < n && seg[j] != SYNC) j++;
      if (j >= n) break;
      verified = 1'b1;
      c = j;
      for (int k = 1; k < LOCKN; k++) begin
        c = j + k * PERIOD;
        if (c >= n || seg[c] != SYNC) begin
          verified = 1'b0;
          break;
        end
      end
      if (!verified) begin
        h = c + 1;
        continue;
      end
      misses = 0;
      done = 1'b0;
      m_lk[c] = 1'b1;
      while (!done) begin
        for (int i = c + 1; i <= c + FL && i < n; i++) begin
          m_en[i] = 1'b1;
          m_fs[i] = (i == c + 1);
          m_lk[i] = 1'b1;
        end
        c += PERIOD;
        if (c >= n) begin
          done = 1'b1;
          h = n;
        end else if (seg[c] == SYNC) begin
          misses = 0;
          m_lk[c] = 1'b1;
        end else begin
          m_err[c] = 1'b1;
          misses++;
          if (misses == UNLOCKN) begin
            done = 1'b1;
            h = c + 1;
          end else begin
            m_lk[c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic run_segment(input string name, input int first, input int last,
                             input int n_reset, input int gap_pct);
    int idx, prev, errs0, outs;
    bit cur_lk;
    errs0 = err_cnt;
    outs = 0;
    seg.delete();
    for (int i = first; i <= last; i++) seg.push_back(syms[i]);
    build_model();
    for (int r = 0; r < n_reset; r++) begin
      @(negedge clk);
      rst = 1'b1;
      data_en_i = 1'b1;
      data_i = DW'($urandom_range(0, 255));
      @(negedge clk);
      rst = 1'b0;
      data_en_i = 1'b0;
      data_i = '0;
      check_eq({name, ":rst_en"},   32'(data_en_o), 32'd0);
      check_eq({name, ":rst_data"}, 32'(data_o), 32'd0);
      check_eq({name, ":rst_fs"},   32'(frame_start_o), 32'd0);
      check_eq({name, ":rst_lock"}, 32'(locked_o), 32'd0);
      check_eq({name, ":rst_err"},  32'(sync_err_o), 32'd0);
    end
    cur_lk = 1'b0;
    idx = 0;
    prev = -2;
    while (1) begin
      @(negedge clk);
      if (prev >= 0) begin
        cur_lk = m_lk[prev];
        if (m_en[prev]) outs++;
        check_eq({name, ":en"},   32'(data_en_o), 32'(m_en[prev]));
        check_eq({name, ":data"}, 32'(data_o), m_en[prev] ? 32'(seg[prev]) : 32'd0);
        check_eq({name, ":fs"},   32'(frame_start_o), 32'(m_fs[prev]));
        check_eq({name, ":err"},  32'(sync_err_o), 32'(m_err[prev]));
        check_eq({name, ":lock"}, 32'(locked_o), 32'(cur_lk));
      end else if (prev == -1) begin
        check_eq({name, ":gap_en"},   32'(data_en_o), 32'd0);
        check_eq({name, ":gap_data"}, 32'(data_o), 32'd0);
        check_eq({name, ":gap_fs"},   32'(frame_start_o), 32'd0);
        check_eq({name, ":gap_err"},  32'(sync_err_o), 32'd0);
        check_eq({name, ":gap_lock"}, 32'(locked_o), 32'(cur_lk));
      end
      if (idx >= seg.size()) begin
        data_en_i = 1'b0;
        data_i = '0;
        break;
      end
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        data_en_i = 1'b0;
        data_i = DW'($urandom_range(0, 255));
        prev = -1;
      end else begin
        data_en_i = 1'b1;
        data_i = DW'(seg[idx]);
        prev = idx;
        idx++;
      end
    end
    $display("segment %-12s symbols=%0d payload_out=%0d new_errors=%0d",
             name, seg.size(), outs, err_cnt - errs0);
  endtask

  initial begin
    // Clean continuous stream, counting payload.
    syms.delete();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0);
    run_segment("clean", 0, syms.size() - 1, 2, 0);

    // One corrupted sync while locked, then recovery.
    syms.delete();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 1);
    add_frame(8'h00, 1);
    for (int f = 0; f < 2; f++) add_frame(SYNC, 1);
    run_segment("one_miss", 0, syms.size() - 1, 1, 0);

    // Three consecutive bad syncs drop lock after two flywheel frames.
    syms.delete();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 2);
    for (int f = 0; f < 3; f++) add_frame(rand_non_sync(), 2);
    add_frame(rand_non_sync(), 2);
    run_segment("three_miss", 0, syms.size() - 1, 1, 0);

    // False sync inside filler, then a genuine sync train.
    syms.delete();
    for (int i = 0; i < 10; i++) syms.push_back(rand_non_sync());
    syms.push_back(SYNC);
    for (int i = 0; i < 300; i++) syms.push_back(rand_non_sync());
    for (int f = 0; f < 4; f++) add_frame(SYNC, 2);
    run_segment("false_sync", 0, syms.size() - 1, 1, 0);

    // Clean stream with 50% input gaps.
    syms.delete();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0);
    run_segment("gappy", 0, syms.size() - 1, 1, 50);

    // Reset at payload symbol 100 of a locked frame, then relock on fresh syncs.
    syms.delete();
    for (int f = 0; f < 4; f++) add_frame(SYNC, 0);
    for (int f = 0; f < 4; f++) add_frame(SYNC, 2);
    run_segment("pre_reset", 0, 3 * PERIOD + 100, 1, 0);
    run_segment("post_reset", 3 * PERIOD + 101, syms.size() - 1, 1, 0);

    // Fully random: junk prefix, random sync corruption, random gaps.
    for (int s = 0; s < 3; s++) begin
      syms.delete();
      for (int i = 0; i < int'($urandom_range(0, 60)); i++)
        syms.push_back(int'($urandom_range(0, 255)));
      for (int f = 0; f < 8; f++)
        add_frame(($urandom_range(0, 99) < 25) ? int'($urandom_range(0, 255)) : SYNC, 1);
      run_segment("random", 0, syms.size() - 1, 1, 30);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
